// File: rtl/frame_bit_counter.sv
// frame_bit_counter
//   Frames a serial transfer into bits. Each bit is made of (smp_lat+1)
//   sample cycles in oversampling mode, or is advanced by an external inc
//   pulse. A frame is (bit_lat+1) bits. Limits are latched at frame start
//   and again at each auto-reload.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; counters parked at 0
//   RUN   | frame in progress; counting samples/bits
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active low
//   ena        in   global enable; 0 freezes counters and state
//   start      in   begin a frame (honoured in IDLE only)
//   abort      in   drop the current frame at once (ignores ena)
//   inc        in   external bit advance (OVERSAMPLE=0 only)
//   auto_rl    in   chain straight into the next frame on completion
//   bit_num    in   last bit index of the frame
//   smp_num    in   last sample index within a bit
//   busy       out  high while in RUN
//   bit_idx    out  current bit index
//   mid_strobe out  one-cycle pulse at mid-bit
//   bit_tick   out  one-cycle pulse at each bit boundary
//   frame_done out  one-cycle pulse at frame completion
module frame_bit_counter #(
  parameter int CNT_W      = 4,
  parameter int SMP_W      = 4,
  parameter int OVERSAMPLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic             abort,
  input  logic             inc,
  input  logic             auto_rl,
  input  logic [CNT_W-1:0] bit_num,
  input  logic [SMP_W-1:0] smp_num,
  output logic             busy,
  output logic [CNT_W-1:0] bit_idx,
  output logic             mid_strobe,
  output logic             bit_tick,
  output logic             frame_done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [SMP_W-1:0] smp_cnt, smp_cnt_nxt;
  logic [CNT_W-1:0] bit_idx_nxt;
  logic [CNT_W-1:0] bit_lat, bit_lat_nxt;
  logic [SMP_W-1:0] smp_lat, smp_lat_nxt;
  logic             mid_nxt, tick_nxt, done_nxt;
  logic             boundary;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      smp_cnt    <= '0;
      bit_idx    <= '0;
      bit_lat    <= '0;
      smp_lat    <= '0;
      mid_strobe <= 1'b0;
      bit_tick   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      smp_cnt    <= smp_cnt_nxt;
      bit_idx    <= bit_idx_nxt;
      bit_lat    <= bit_lat_nxt;
      smp_lat    <= smp_lat_nxt;
      mid_strobe <= mid_nxt;
      bit_tick   <= tick_nxt;
      frame_done <= done_nxt;
    end
  end

  // A bit ends either on the last sample of the bit or on an external inc.
  always_comb begin
    if (OVERSAMPLE != 0) boundary = (smp_cnt == smp_lat);
    else                 boundary = inc;
  end

  always_comb begin
    state_nxt   = state;
    smp_cnt_nxt = smp_cnt;
    bit_idx_nxt = bit_idx;
    bit_lat_nxt = bit_lat;
    smp_lat_nxt = smp_lat;
    mid_nxt     = 1'b0;
    tick_nxt    = 1'b0;
    done_nxt    = 1'b0;

    if (abort) begin
      // abort outranks start, ena and any boundary on the same edge
      state_nxt   = IDLE;
      smp_cnt_nxt = '0;
      bit_idx_nxt = '0;
    end else if (ena) begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_nxt   = RUN;
            bit_lat_nxt = bit_num;
            smp_lat_nxt = smp_num;
            smp_cnt_nxt = '0;
            bit_idx_nxt = '0;
          end
        end
        RUN: begin
          if (OVERSAMPLE != 0) begin
            mid_nxt     = (smp_cnt == (smp_lat >> 1));
            smp_cnt_nxt = boundary ? '0 : SMP_W'(smp_cnt + 1'b1);
          end else begin
            smp_cnt_nxt = '0;
          end
          if (boundary) begin
            tick_nxt = 1'b1;
            if (bit_idx == bit_lat) begin
              bit_idx_nxt = '0;
              done_nxt    = 1'b1;
              if (auto_rl) begin
                bit_lat_nxt = bit_num;
                smp_lat_nxt = smp_num;
              end else begin
                state_nxt = IDLE;
              end
            end else begin
              bit_idx_nxt = CNT_W'(bit_idx + 1'b1);
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);

endmodule
